sd_route_ctrl: RTL and testbench

SD_ROUTE_CTRL -- requirements
Module: sd_route_ctrl

---
 rtl/sd_route_pkg.sv | 16 +
 rtl/sd_act_timer.sv | 41 ++++
 rtl/sd_route_ctrl.sv | 120 ++++++++++++
 tb/tb_sd_route_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sd_route_pkg.sv
// sd_route_pkg: shared types and default constants for the SD routing block.
//   sd_route_state_t : routing FSM state (physical card, virtual card, switch pending)
//   DEF_ACT_TIMEOUT  : default activity-hold time in clk_sys cycles
//   DEF_MRST_LEN     : default mount-reset pulse length in cycles
package sd_route_pkg;

  typedef enum logic [1:0] {
    ST_PHYS = 2'd0,
    ST_VIRT = 2'd1,
    ST_PEND = 2'd2
  } sd_route_state_t;

  localparam int DEF_ACT_TIMEOUT = 1000000;
  localparam int DEF_MRST_LEN    = 16;

endpackage

// File: rtl/sd_act_timer.sv
// sd_act_timer: bus activity indicator.
//   clk_sys : clock
//   reset_n : async active-low reset
//   toggle  : 1 when a monitored bus line changed this cycle
//   act     : registered, 1 while fewer than ACT_TIMEOUT idle cycles have elapsed
module sd_act_timer #(
  parameter int ACT_TIMEOUT = 1000000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic toggle,
  output logic act
);

  localparam int            CW   = $clog2(ACT_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(ACT_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;

  // Saturates at CMAX so a long idle bus never wraps back to "active".
  always_comb begin
    cnt_d = cnt_q;
    if (toggle)             cnt_d = '0;
    else if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
    act_d = (cnt_d < CMAX);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      act_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign act = act_q;

endmodule

// File: rtl/sd_route_ctrl.sv
// sd_route_ctrl: routes the core SPI bus to either the physical SD card or a
// virtual card, switching only between transactions (spi_ss high).
//   clk_sys, reset_n           : clock, async active-low reset
//   img_mounted, img_nz        : mount strobe and nonzero-image flag
//   spi_sck/ss/mosi, spi_miso  : core SPI bus
//   vsd_ss, vsd_miso           : virtual card select / data
//   SD_CS/SCK/MOSI, SD_MISO    : physical card
//   vsd_sel, pend              : routing state, switch pending
//   sd_act, mnt_rst            : activity indicator, post-mount core reset
module sd_route_ctrl import sd_route_pkg::*; #(
  parameter int ACT_TIMEOUT = DEF_ACT_TIMEOUT,
  parameter int MRST_LEN    = DEF_MRST_LEN
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic img_mounted,
  input  logic img_nz,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic vsd_ss,
  input  logic vsd_miso,
  output logic SD_CS,
  output logic SD_SCK,
  output logic SD_MOSI,
  input  logic SD_MISO,
  output logic vsd_sel,
  output logic pend,
  output logic sd_act,
  output logic mnt_rst
);

  sd_route_state_t state_q, state_d;
  logic            tgt_q, tgt_d;
  logic            sel_q, sel_d;
  logic            mosi_q, miso_q;
  logic [7:0]      mcnt_q, mcnt_d;
  logic            mnt_rst_q, mnt_rst_d;
  logic            toggle;

  // Routing FSM. sel_q holds the routed card; in PEND it keeps the
  // pre-request value. The target used on PEND exit is tgt_d so a mount
  // arriving in the same cycle as the spi_ss release takes effect at once.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = img_mounted ? img_nz : tgt_q;
    case (state_q)
      ST_PHYS, ST_VIRT: begin
        if (img_mounted && (img_nz != sel_q)) begin
          if (spi_ss) begin
            sel_d   = img_nz;
            state_d = img_nz ? ST_VIRT : ST_PHYS;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (spi_ss) begin
          sel_d   = tgt_d;
          state_d = tgt_d ? ST_VIRT : ST_PHYS;
        end
      end
      default: begin
        state_d = ST_PHYS;
        sel_d   = 1'b0;
      end
    endcase
  end

  // Mount reset pulse: reload on every mount, count down to zero.
  always_comb begin
    mcnt_d = mcnt_q;
    if (img_mounted)        mcnt_d = 8'(MRST_LEN);
    else if (mcnt_q != 8'd0) mcnt_d = mcnt_q - 8'd1;
    mnt_rst_d = (mcnt_d != 8'd0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PHYS;
      tgt_q     <= 1'b0;
      sel_q     <= 1'b0;
      mosi_q    <= 1'b0;
      miso_q    <= 1'b0;
      mcnt_q    <= 8'd0;
      mnt_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      sel_q     <= sel_d;
      mosi_q    <= spi_mosi;
      miso_q    <= spi_miso;
      mcnt_q    <= mcnt_d;
      mnt_rst_q <= mnt_rst_d;
    end
  end

  assign toggle = (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);

  sd_act_timer #(.ACT_TIMEOUT(ACT_TIMEOUT)) u_act (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .toggle  (toggle),
    .act     (sd_act)
  );

  // Both cards stay deselected while a switch is pending.
  assign vsd_sel  = sel_q;
  assign pend     = (state_q == ST_PEND);
  assign SD_CS    = spi_ss | vsd_sel | pend;
  assign vsd_ss   = spi_ss | ~vsd_sel | pend;
  assign SD_SCK   = spi_sck & ~SD_CS;
  assign SD_MOSI  = spi_mosi & ~SD_CS;
  assign spi_miso = vsd_sel ? vsd_miso : SD_MISO;
  assign mnt_rst  = mnt_rst_q;

endmodule

// File: tb/tb_sd_route_ctrl.sv
// tb_sd_route_ctrl: directed + randomized bench against a behavioural model.
// ACT_TIMEOUT is shortened so the idle-timeout behaviour fits a short run.
module tb_sd_route_ctrl;

  localparam int T_ACT = 40;
  localparam int T_MR  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic img_mounted = 0, img_nz = 0, spi_sck = 0, spi_ss = 1, spi_mosi = 0;
  logic vsd_miso = 0, SD_MISO = 0;
  logic spi_miso, vsd_ss, SD_CS, SD_SCK, SD_MOSI, vsd_sel, pend, sd_act, mnt_rst;

  always #5 clk = ~clk;

  sd_route_ctrl #(.ACT_TIMEOUT(T_ACT), .MRST_LEN(T_MR)) dut (
    .clk_sys(clk), .reset_n(reset_n), .img_mounted(img_mounted), .img_nz(img_nz),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .vsd_ss(vsd_ss), .vsd_miso(vsd_miso), .SD_CS(SD_CS), .SD_SCK(SD_SCK),
    .SD_MOSI(SD_MOSI), .SD_MISO(SD_MISO), .vsd_sel(vsd_sel), .pend(pend),
    .sd_act(sd_act), .mnt_rst(mnt_rst)
  );

  int n_chk = 0, n_fail = 0;

  // Behavioural model: which card is routed, whether a switch waits,
  // remaining mount-reset cycles, idle cycles since the last bus change.
  bit m_sel, m_pend, m_tgt;
  int m_mrem, m_idle;
  bit p_mosi, p_miso;

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_tgt = 0; m_mrem = 0; m_idle = 0; p_mosi = 0; p_miso = 0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    bit e_cs;
    e_cs = spi_ss | m_sel | m_pend;
    chk("vsd_sel", vsd_sel, m_sel);
    chk("pend", pend, m_pend);
    chk("mnt_rst", mnt_rst, m_mrem > 0);
    chk("sd_act", sd_act, m_idle < T_ACT);
    chk("SD_CS", SD_CS, e_cs);
    chk("vsd_ss", vsd_ss, spi_ss | ~m_sel | m_pend);
    chk("SD_SCK", SD_SCK, spi_sck & ~e_cs);
    chk("SD_MOSI", SD_MOSI, spi_mosi & ~e_cs);
    chk("spi_miso", spi_miso, m_sel ? vsd_miso : SD_MISO);
  endtask

  // One clock: apply inputs, advance model on the edge, check #1 later.
  task automatic cyc(input bit im, input bit nz, input bit ss, input bit sck,
                     input bit mosi, input bit vm, input bit sm);
    bit miso_now;
    img_mounted = im; img_nz = nz; spi_ss = ss; spi_sck = sck;
    spi_mosi = mosi; vsd_miso = vm; SD_MISO = sm;
    miso_now = m_sel ? vm : sm;
    @(posedge clk);
    if (im) m_tgt = nz;
    if (!m_pend) begin
      if (im && nz != m_sel) begin
        if (ss) m_sel = nz; else m_pend = 1;
      end
    end else if (ss) begin
      m_sel = m_tgt; m_pend = 0;
    end
    if (im) m_mrem = T_MR; else if (m_mrem > 0) m_mrem--;
    if (mosi != p_mosi || miso_now != p_miso) m_idle = 0;
    else if (m_idle < T_ACT) m_idle++;
    p_mosi = mosi; p_miso = miso_now;
    #1;
    chk_all();
  endtask

  task automatic idle(input int n, input bit ss);
    for (int i = 0; i < n; i++) cyc(0, 0, ss, 0, 0, 0, 0);
  endtask

  int hi_cnt;
  int act_hi;
  bit quiet, r_ss, r_mosi, r_vm, r_sm;

  initial begin
    model_reset();
    #23;
    chk_all();
    @(negedge clk) reset_n = 1;

    // Idle bus after reset: sd_act high for exactly T_ACT cycles.
    act_hi = 1;
    for (int i = 0; i < T_ACT + 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (sd_act) act_hi++;
    end
    chk("act_hold_len", act_hi == T_ACT, 1'b1);

    // Mount with bus idle: switch next cycle, mnt_rst 16 cycles.
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("direct_virt", vsd_sel, 1'b1);
    chk("direct_sdcs", SD_CS, 1'b1);
    hi_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0);
      if (mnt_rst) hi_cnt++;
    end
    chk("mnt_len16", hi_cnt == T_MR, 1'b1);

    // Same target again: no change.
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("same_tgt", vsd_sel, 1'b1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("back_phys", vsd_sel, 1'b0);

    // Mount mid-transaction: pend until spi_ss rises.
    cyc(1, 1, 0, 1, 1, 0, 1);
    chk("pend_set", pend, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, i[0], ~i[1], 1, i[0]);
    chk("pend_hold_sel", vsd_sel, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pend_exit_virt", vsd_sel, 1'b1);
    idle(3, 1);

    // Pend then cancel with a second mount.
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("cancel_still_pend", pend, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("cancel_phys", vsd_sel, 1'b0);
    chk("cancel_nopend", pend, 1'b0);

    // Re-trigger 5 cycles after first mount: 21 cycles of mnt_rst.
    idle(20, 1);
    hi_cnt = 0;
    cyc(1, 0, 1, 0, 0, 0, 0);
    if (mnt_rst) hi_cnt++;
    for (int i = 1; i < 40; i++) begin
      cyc(i == 5, 0, 1, 0, 0, 0, 0);
      if (mnt_rst) hi_cnt++;
    end
    chk("mnt_retrig21", hi_cnt == 21, 1'b1);

    // Reset during PEND.
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_pend", pend, 1'b1);
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("rst_sel", vsd_sel, 1'b0);
    chk("rst_pend", pend, 1'b0);
    chk("rst_mnt", mnt_rst, 1'b0);
    chk_all();
    @(negedge clk) reset_n = 1;
    idle(3, 1);
    chk("post_rst_phys", vsd_sel, 1'b0);

    // Randomized traffic with quiet phases so the activity timer expires.
    quiet = 0; r_ss = 1; r_mosi = 0; r_vm = 0; r_sm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) quiet = ~quiet;
      if ($urandom_range(0, 5) == 0) r_ss = ~r_ss;
      if (!quiet) begin
        r_mosi = 1'($urandom); r_vm = 1'($urandom); r_sm = 1'($urandom);
      end
      cyc($urandom_range(0, 19) == 0, 1'($urandom), r_ss, 1'($urandom),
          r_mosi, r_vm, r_sm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
